// File: rtl/wm_i2s_master.sv
// I2S master serialiser: divides clk down to bclk and sends one
// mono sample per frame on both the left and right slots.
module wm_i2s_master #(
  parameter int BCLK_DIV    = 4,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SAMPLE_BITS-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   aud_bclk,
  output logic                   aud_daclrc,
  output logic                   aud_dacdat,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam logic [7:0] DIV_MAX = 8'(BCLK_DIV - 1);
  localparam logic [4:0] SB      = 5'(SAMPLE_BITS);

  logic [7:0]             div_q, div_d;
  logic [5:0]             bit_q, bit_d, bit_n;
  logic [SAMPLE_BITS-1:0] word_q, word_d;
  logic [SAMPLE_BITS-1:0] hold_q, hold_d;
  logic                   full_q, full_d;
  logic                   bclk_d, lrc_d, dat_d;
  logic                   fs_d, ur_d;
  logic                   tick, rise, load, xfer;
  logic [4:0]             slot, idx;
  logic [31:0]            word_x;
  logic                   dat_n;

  assign s_ready = ~full_q;
  assign xfer    = s_valid & ~full_q;
  assign tick    = en & (div_q == DIV_MAX);
  assign rise    = tick & ~aud_bclk;
  assign bit_n   = bit_q + 6'd1;
  assign load    = rise & (bit_n == 6'd0);

  // Slot position is the same for both halves of the frame
  assign slot   = bit_n[4:0];
  assign idx    = SB - slot;
  assign word_x = 32'(word_q);
  assign dat_n  = (slot != 5'd0) && (slot <= SB) ? word_x[idx] : 1'b0;

  always_comb begin
    div_d  = div_q;
    bit_d  = bit_q;
    bclk_d = aud_bclk;
    lrc_d  = aud_daclrc;
    dat_d  = aud_dacdat;
    fs_d   = 1'b0;
    ur_d   = 1'b0;
    word_d = word_q;
    hold_d = hold_q;
    full_d = full_q;

    if (xfer) begin
      hold_d = s_data;
      full_d = 1'b1;
    end else if (load && full_q) begin
      full_d = 1'b0;
    end

    // No bypass: an empty holding register repeats the last word
    if (load) begin
      fs_d = 1'b1;
      if (full_q) word_d = hold_q;
      else        ur_d   = 1'b1;
    end

    unique case (1'b1)
      !en: begin
        div_d  = 8'd0;
        bit_d  = 6'h3f;
        bclk_d = 1'b0;
        lrc_d  = 1'b1;
        dat_d  = 1'b0;
      end
      tick: begin
        div_d  = 8'd0;
        bclk_d = ~aud_bclk;
        if (rise) begin
          bit_d = bit_n;
          lrc_d = bit_n[5];
          dat_d = dat_n;
        end
      end
      default: div_d = div_q + 8'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= 8'd0;
      bit_q       <= 6'h3f;
      aud_bclk    <= 1'b0;
      aud_daclrc  <= 1'b1;
      aud_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      word_q      <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      aud_bclk    <= bclk_d;
      aud_daclrc  <= lrc_d;
      aud_dacdat  <= dat_d;
      frame_start <= fs_d;
      underrun    <= ur_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
    end
  end

endmodule

// File: tb/tb_wm_i2s_master.sv
// Bench for wm_i2s_master: cycle-timed reference model derived from
// elapsed enabled clocks, plus directed frame captures.
module tb_wm_i2s_master;

  localparam int DIV   = 4;
  localparam int SB    = 16;
  localparam int FRAME = 128 * DIV;

  logic          clk = 1'b0;
  logic          rst, en, s_valid;
  logic [SB-1:0] s_data;
  logic          s_ready, aud_bclk, aud_daclrc, aud_dacdat;
  logic          frame_start, underrun;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wm_i2s_master #(.BCLK_DIV(DIV), .SAMPLE_BITS(SB)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .aud_bclk(aud_bclk), .aud_daclrc(aud_daclrc),
    .aud_dacdat(aud_dacdat), .frame_start(frame_start),
    .underrun(underrun)
  );

  // Reference model: bclk phase follows from clocks elapsed since enable
  int            m_ph, m_bc, m_slot;
  logic          m_bclk, m_lrc, m_dat, m_fs, m_ur;
  logic [SB-1:0] m_word;
  logic [SB-1:0] m_q[$];
  bit            m_full, m_acc;

  always @(posedge clk) begin
    m_full = (m_q.size() != 0);
    m_acc  = s_valid && !m_full;
    m_fs   = 1'b0;
    m_ur   = 1'b0;
    if (rst) begin
      m_ph = 0; m_bc = 63; m_bclk = 0; m_lrc = 1; m_dat = 0;
      m_word = '0;
      m_q.delete();
    end else begin
      if (!en) begin
        m_ph = 0; m_bc = 63; m_bclk = 0; m_lrc = 1; m_dat = 0;
      end else begin
        m_ph++;
        m_bclk = ((m_ph / DIV) % 2) == 1;
        if (m_ph % (2 * DIV) == DIV) begin
          m_bc = ((m_ph - DIV) / (2 * DIV)) % 64;
          if (m_bc == 0) begin
            m_fs = 1'b1;
            if (m_full) m_word = m_q.pop_front();
            else        m_ur = 1'b1;
          end
          m_lrc  = (m_bc >= 32);
          m_slot = m_bc % 32;
          m_dat  = (m_slot >= 1 && m_slot <= SB) ? m_word[SB-m_slot] : 1'b0;
        end
      end
      if (m_acc) m_q.push_back(s_data);
    end
  end

  // Capture the serial bits of each frame at bclk rising edges
  logic prev_bclk = 1'b0;
  logic cap  [64];
  logic last [64];
  int   k = 0;

  always @(negedge clk) begin
    if (aud_bclk && !prev_bclk) begin
      if (frame_start) begin
        last = cap;
        k = 0;
      end else begin
        k++;
      end
      if (k < 64) cap[k] = aud_dacdat;
    end
    prev_bclk = aud_bclk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk1("bclk", aud_bclk, m_bclk);
    chk1("daclrc", aud_daclrc, m_lrc);
    chk1("dacdat", aud_dacdat, m_dat);
    chk1("frame_start", frame_start, m_fs);
    chk1("underrun", underrun, m_ur);
    chk1("s_ready", s_ready, m_q.size() == 0);
  endtask

  task automatic slot_word(input int base, output logic [15:0] w);
    w = '0;
    for (int i = 1; i <= SB; i++) w = {w[14:0], last[base+i]};
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp);
    logic [15:0] l, r;
    int nz;
    slot_word(0, l);
    slot_word(32, r);
    nz = 0;
    for (int i = 0; i < 64; i++)
      if (!((i >= 1 && i <= SB) || (i >= 33 && i <= 32 + SB)))
        if (last[i] !== 1'b0) nz++;
    chk16({tag, "_left"}, l, exp);
    chk16({tag, "_right"}, r, exp);
    chk16({tag, "_pad"}, 16'(nz), 16'd0);
  endtask

  task automatic wait_fs(input string tag);
    bit found = 0;
    for (int i = 0; i < FRAME + 16 && !found; i++) begin
      step();
      if (frame_start) found = 1;
    end
    chk1(tag, found, 1'b1);
  endtask

  int ur_cnt, rdy_cnt;
  bit hit;

  initial begin
    rst = 1; en = 0; s_valid = 0; s_data = '0;
    repeat (3) step();
    chk1("rst_ready", s_ready, 1'b1);
    chk1("rst_lrc", aud_daclrc, 1'b1);
    chk1("rst_bclk", aud_bclk, 1'b0);

    // Preload 0xA5C3 then enable
    rst = 0; s_data = 16'hA5C3; s_valid = 1;
    step();
    s_valid = 0;
    step();
    chk1("preload_full", s_ready, 1'b0);
    en = 1;
    ur_cnt = 0;
    repeat (FRAME + DIV + 20) begin
      step();
      if (underrun) ur_cnt++;
    end
    check_frame("f1", 16'hA5C3);
    chk16("f2_underruns", 16'(ur_cnt), 16'd1);
    repeat (FRAME) step();
    check_frame("f2_repeat", 16'hA5C3);

    // Random offers
    repeat (3 * FRAME) begin
      s_valid = ($urandom_range(0, 3) == 0);
      s_data  = SB'($urandom);
      step();
    end

    // Continuous valid: one transfer per frame
    s_valid = 1;
    wait_fs("cont_sync");
    repeat (2) begin
      rdy_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) begin
          s_data = SB'($urandom);
          step();
        end
        if (s_ready) rdy_cnt++;
      end
      chk16("xfer_per_frame", 16'(rdy_cnt), 16'd1);
    end

    // Offer lands exactly on frame start with empty holding register
    s_valid = 0;
    wait_fs("drain_fs");
    hit = 0;
    for (int i = 0; i < FRAME + 16 && !hit; i++) begin
      if ((m_ph + 1 - DIV) % FRAME == 0) hit = 1;
      else step();
    end
    chk1("align_fs", hit, 1'b1);
    s_data = 16'h1234; s_valid = 1;
    step();
    s_valid = 0;
    chk1("coinc_underrun", underrun, 1'b1);
    chk1("coinc_fs", frame_start, 1'b1);
    chk1("coinc_held", s_ready, 1'b0);
    repeat (2 * FRAME + 20) step();
    check_frame("coinc_next", 16'h1234);

    // Drop enable at bit 20, then re-enable
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      step();
      if (m_bc == 20) hit = 1;
    end
    chk1("reach_bit20", hit, 1'b1);
    en = 0;
    step();
    chk1("idle_bclk", aud_bclk, 1'b0);
    chk1("idle_lrc", aud_daclrc, 1'b1);
    chk1("idle_dat", aud_dacdat, 1'b0);
    repeat (5) step();
    en = 1;
    repeat (DIV - 1) step();
    chk1("pre_rise", aud_bclk, 1'b0);
    step();
    chk1("first_rise", aud_bclk, 1'b1);
    chk1("first_lrc", aud_daclrc, 1'b0);
    chk1("first_fs", frame_start, 1'b1);

    // Reset mid-frame
    s_data = 16'hFFFF; s_valid = 1;
    repeat (300) step();
    s_valid = 1;
    rst = 1;
    step();
    chk1("mrst_bclk", aud_bclk, 1'b0);
    chk1("mrst_lrc", aud_daclrc, 1'b1);
    chk1("mrst_ready", s_ready, 1'b1);
    rst = 0; s_valid = 0;
    repeat (DIV) step();
    chk1("mrst_underrun", underrun, 1'b1);
    repeat (FRAME + 20) step();
    check_frame("mrst_zero", 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wm_i2s_master.md
WM_I2S_MASTER -- requirements
Module: wm_i2s_master

Interface
REQ-001 The block SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per aud_bclk half-period (legal range 2..255).
REQ-002 The block SHALL have parameter SAMPLE_BITS, default 16, meaning audio word width (legal range 1..31).
REQ-003 The block SHALL have port clk  input  1  system clock; the block's only clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 The block SHALL have port en  input  1  serialiser enable.
REQ-006 The block SHALL have port s_data  input  SAMPLE_BITS  two's-complement sample from the DDS.
REQ-007 The block SHALL have port s_valid  input  1  s_data valid.
REQ-008 The block SHALL have port s_ready  output  1  holding register empty, sample accepted.
REQ-009 The block SHALL have port aud_bclk  output  1  I2S bit clock to codec.
REQ-010 The block SHALL have port aud_daclrc  output  1  left/right word select; 0 = left.
REQ-011 The block SHALL have port aud_dacdat  output  1  serial data, MSB first.
REQ-012 The block SHALL have port frame_start  output  1  one-clk pulse at each left-slot start.
REQ-013 The block SHALL have port underrun  output  1  one-clk pulse when a frame starts with no new sample.

Function
REQ-014 All outputs SHALL be registered, and all state SHALL change only on rising clk.
REQ-015 The divider SHALL count 0..BCLK_DIV-1 while en=1 and toggle aud_bclk when the count equals BCLK_DIV-1, giving a bclk period of 2*BCLK_DIV clk cycles.
REQ-016 bit_cnt (6 bits, 0..63) SHALL advance by 1, wrapping 63->0, in the same clk cycle that aud_bclk is driven 0->1.
REQ-017 aud_daclrc and aud_dacdat SHALL update only with the aud_bclk 0->1 transition, so they are stable at every bclk falling edge.
REQ-018 aud_daclrc SHALL be 0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
REQ-019 aud_dacdat SHALL output shift-register bit SAMPLE_BITS-1 down to 0 at bit_cnt 1..SAMPLE_BITS (left) and at 33..32+SAMPLE_BITS (right, same sample), and SHALL output 0 at all other bit_cnt values.
REQ-020 The holding register SHALL be a one-entry buffer; s_ready SHALL equal NOT hold_full, and a transfer SHALL occur when s_valid=1 and s_ready=1.
REQ-021 On the transition to bit_cnt 0, the shift register SHALL load from the holding register if hold_full=1 and clear hold_full; otherwise it SHALL reload the previous sample and pulse underrun.
REQ-022 frame_start SHALL pulse in the same clk cycle as every transition to bit_cnt 0.
REQ-023 A transfer in the same clk cycle as frame-start load with the holding register empty SHALL fill the holding register for the next frame (no bypass), and underrun SHALL still pulse.
REQ-024 While en=0, the block SHALL hold aud_bclk=0, aud_daclrc=1, aud_dacdat=0, divider=0 and bit_cnt=63; the holding register SHALL keep accepting one sample.
REQ-025 When en rises, the first aud_bclk 0->1 transition SHALL occur BCLK_DIV clk cycles later and SHALL start a frame (bit_cnt 0).
REQ-026 When en falls mid-frame, the block SHALL go to the REQ-024 state on the next clk, abandoning the frame.

Reset
REQ-027 When rst=1, the block SHALL set aud_bclk=0, aud_daclrc=1, aud_dacdat=0, frame_start=0, underrun=0, divider=0, bit_cnt=63, shift register=0 and hold_full=0 (s_ready=1).
REQ-028 rst SHALL take priority over en and over s_valid in every cycle, including mid-frame.

Verification
REQ-029 The bench SHALL cover: BCLK_DIV=4, s_data=16'hA5C3 preloaded, en=1 -> bclk period 8 clk; left slot bits 1..16 = 1010010111000011; right slot bits 33..48 identical; remaining bits 0.
REQ-030 The bench SHALL cover: no sample offered before the second frame -> underrun pulses once at that frame_start, and the frame repeats the previous word.
REQ-031 The bench SHALL cover: s_valid held high continuously -> exactly one transfer per 64 bclk periods, and s_ready low from the transfer until the next frame_start.
REQ-032 The bench SHALL cover: s_valid=1 with the holding register empty in the frame_start cycle -> underrun pulses, the sample is held, and it is transmitted in the following frame.
REQ-033 The bench SHALL cover: en dropped at bit_cnt 20, then raised again -> outputs idle (0,1,0) next clk; the first bclk rising edge comes 4 clk after en rises, with daclrc falling at that edge.
REQ-034 The bench SHALL cover: rst asserted mid-frame -> REQ-027 values on the next clk; after release, the first frame reports underrun and transmits 0.
